// File: rtl/adc_capture_scheduler_if.sv
// Capture-controller / DMA handshake bundle for adc_capture_scheduler.
// master = scheduler side, slave = capture controller side.
interface adc_capture_scheduler_if;
  logic        sample_start;
  logic [31:0] sample_len;
  logic        st_clr;
  logic        dma_tlast;

  modport master (
    output sample_start,
    output sample_len,
    input  st_clr,
    input  dma_tlast
  );

  modport slave (
    input  sample_start,
    input  sample_len,
    output st_clr,
    output dma_tlast
  );
endinterface

// File: rtl/adc_capture_scheduler.sv
// Frame scheduler: sequences trigger, capture request, DMA completion
// and inter-frame interval for a run of ADC frames.
module adc_capture_scheduler #(
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned DMA_TIMEOUT = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    cfg_sample_len,
  input  logic [15:0]                    cfg_frames,
  input  logic [31:0]                    cfg_interval,
  input  logic                           cfg_ext_trig_en,
  input  logic                           arm,
  input  logic                           abort,
  input  logic                           ext_trig,
  adc_capture_scheduler_if.master        cap,
  output logic                           busy,
  output logic [15:0]                    frame_cnt,
  output logic                           done,
  output logic                           err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_WAIT_ACK,
    S_CAPTURE,
    S_WAIT_DMA,
    S_INTERVAL,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] frames_q;
  logic [31:0] interval_q;
  logic        trig_en_q;
  logic        ext_trig_q;
  logic [31:0] tmo_cnt;
  logic [32:0] tmo_p1;
  logic        tlast_seen;
  logic        abort_pend;

  logic        arm_ok;
  logic        dma_exit;
  logic        trig_rise;
  logic [15:0] cnt_inc;
  logic        in_frame_nxt;
  logic        in_frame;

  assign tmo_p1    = {1'b0, tmo_cnt} + 33'd1;
  assign trig_rise = ext_trig & ~ext_trig_q;
  assign cnt_inc   = frame_cnt + 16'd1;

  assign in_frame = (state == S_WAIT_ACK) ||
                    (state == S_CAPTURE)  ||
                    (state == S_WAIT_DMA);

  assign in_frame_nxt = (state_nxt == S_WAIT_ACK) ||
                        (state_nxt == S_CAPTURE)  ||
                        (state_nxt == S_WAIT_DMA);

  always_comb begin
    state_nxt = state;
    arm_ok    = 1'b0;
    dma_exit  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (arm && !abort && (cfg_sample_len != 32'd0)) begin
          arm_ok    = 1'b1;
          state_nxt = S_WAIT_TRIG;
        end
      end
      S_WAIT_TRIG: begin
        if (abort)
          state_nxt = S_DONE;
        else if (!trig_en_q || trig_rise)
          state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (cap.st_clr)
          state_nxt = S_CAPTURE;
        else if (tmo_p1 >= 33'(ACK_TIMEOUT))
          state_nxt = S_ERROR;
      end
      S_CAPTURE: begin
        if (!cap.st_clr)
          state_nxt = S_WAIT_DMA;
      end
      S_WAIT_DMA: begin
        if (tlast_seen || cap.dma_tlast) begin
          dma_exit = 1'b1;
          // a same-cycle abort still ends the run after this frame
          if (((frames_q != 16'd0) && (cnt_inc == frames_q)) ||
              abort_pend || abort)
            state_nxt = S_DONE;
          else
            state_nxt = S_INTERVAL;
        end else if ((DMA_TIMEOUT != 0) &&
                     (tmo_p1 >= 33'(DMA_TIMEOUT))) begin
          state_nxt = S_ERROR;
        end
      end
      S_INTERVAL: begin
        if (abort)
          state_nxt = S_DONE;
        else if (tmo_p1 >= {1'b0, interval_q})
          state_nxt = S_WAIT_TRIG;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERROR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cap.sample_start <= 1'b0;
      cap.sample_len   <= '0;
      frames_q         <= '0;
      interval_q       <= '0;
      trig_en_q        <= 1'b0;
      ext_trig_q       <= 1'b0;
      tmo_cnt          <= '0;
      tlast_seen       <= 1'b0;
      abort_pend       <= 1'b0;
      frame_cnt        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      state      <= state_nxt;
      ext_trig_q <= ext_trig;

      if ((state_nxt != state) || (state_nxt == S_IDLE))
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_p1[31:0];

      if (arm_ok) begin
        cap.sample_len <= cfg_sample_len;
        frames_q       <= cfg_frames;
        interval_q     <= cfg_interval;
        trig_en_q      <= cfg_ext_trig_en;
        frame_cnt      <= '0;
      end else if (dma_exit) begin
        frame_cnt <= cnt_inc;
      end

      // a tlast beat may land before st_clr drops; remember it
      if (!in_frame_nxt)
        tlast_seen <= 1'b0;
      else if (in_frame && cap.dma_tlast)
        tlast_seen <= 1'b1;

      if ((state_nxt == S_DONE) || (state_nxt == S_ERROR) ||
          (state_nxt == S_IDLE))
        abort_pend <= 1'b0;
      else if (in_frame && abort)
        abort_pend <= 1'b1;

      if (state_nxt == S_ERROR)
        err_timeout <= 1'b1;
      else if (arm_ok)
        err_timeout <= 1'b0;

      cap.sample_start <= (state_nxt == S_WAIT_ACK);
      busy             <= (state_nxt != S_IDLE) && (state_nxt != S_ERROR);
      done             <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_adc_capture_scheduler.sv
// Bench for adc_capture_scheduler: timeline predicted from frame
// arithmetic, capture controller emulated with configurable delays.
`timescale 1ns/1ps
module tb_adc_capture_scheduler;

  localparam int unsigned ACK_TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_sample_len = '0;
  logic [15:0] cfg_frames = '0;
  logic [31:0] cfg_interval = '0;
  logic        cfg_ext_trig_en = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        ext_trig = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        done;
  logic        err_timeout;

  adc_capture_scheduler_if cap ();

  adc_capture_scheduler #(
    .ACK_TIMEOUT(ACK_TO),
    .DMA_TIMEOUT(0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_sample_len (cfg_sample_len),
    .cfg_frames     (cfg_frames),
    .cfg_interval   (cfg_interval),
    .cfg_ext_trig_en(cfg_ext_trig_en),
    .arm            (arm),
    .abort          (abort),
    .ext_trig       (ext_trig),
    .cap            (cap),
    .busy           (busy),
    .frame_cnt      (frame_cnt),
    .done           (done),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  int   ss_q[$];
  int   done_q[$];
  logic ss_prev = 1'b0;

  always @(negedge clk) begin
    if (cap.sample_start && !ss_prev) ss_q.push_back(cyc);
    ss_prev = cap.sample_start;
    if (done) done_q.push_back(cyc);
  end

  // capture controller: st_clr r_ack cycles after request, high r_hi,
  // tlast r_tl cycles after st_clr falls (0 = same cycle)
  logic resp_en = 1'b0;
  logic resp_busy = 1'b0;
  int   r_ack = 2;
  int   r_hi = 10;
  int   r_tl = 5;

  initial begin
    cap.st_clr    = 1'b0;
    cap.dma_tlast = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && cap.sample_start) begin
        resp_busy = 1'b1;
        repeat (r_ack) @(posedge clk);
        #1 cap.st_clr = 1'b1;
        repeat (r_hi) @(posedge clk);
        #1 cap.st_clr = 1'b0;
        if (r_tl > 0) begin
          repeat (r_tl) @(posedge clk);
          #1;
        end
        cap.dma_tlast = 1'b1;
        @(posedge clk);
        #1 cap.dma_tlast = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: cycle %0d reached, limit 50000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic do_arm(input logic [31:0] len, input logic [15:0] nf,
                        input logic [31:0] iv, input logic trig,
                        output int a_edge);
    @(negedge clk);
    cfg_sample_len  = len;
    cfg_frames      = nf;
    cfg_interval    = iv;
    cfg_ext_trig_en = trig;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    a_edge = cyc;
    cfg_sample_len  = $urandom;
    cfg_frames      = 16'($urandom_range(1, 9));
    cfg_interval    = $urandom_range(40, 90);
    cfg_ext_trig_en = ~trig;
  endtask

  function automatic int per_frame(input int a, input int h, input int t);
    return a + h + ((t > 0) ? t : 1) + 1;
  endfunction

  task automatic run_frames(input string nm, input logic [31:0] len,
                            input int nf, input int iv, input int a,
                            input int h, input int t);
    int ae, s, e, de;
    int exp_ss[$];
    r_ack = a; r_hi = h; r_tl = t; resp_en = 1'b1;
    ss_q.delete(); done_q.delete();
    do_arm(len, 16'(nf), 32'(iv), 1'b0, ae);
    s = ae + 1; de = ae;
    for (int f = 0; f < nf; f++) begin
      exp_ss.push_back(s);
      e = s + per_frame(a, h, t);
      if (f == nf - 1) de = e;
      else s = e + ((iv > 0) ? iv : 1) + 1;
    end
    while (cyc < de + 1) begin
      @(negedge clk);
      if (cyc == de) begin
        n_vec++;
        if (busy !== 1'b1 || frame_cnt !== 16'(nf)) begin
          n_err++;
          $display("FAIL %s done_state: busy=%0b frame_cnt=%0d want busy=1 frame_cnt=%0d",
                   nm, busy, frame_cnt, nf);
        end
      end
    end
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: busy=%0b done=%0b want 0 0", nm, busy, done);
    end
    n_vec++;
    if (ss_q.size() != nf) begin
      n_err++;
      $display("FAIL %s start_count: got %0d want %0d", nm, ss_q.size(), nf);
    end
    for (int f = 0; f < nf; f++) begin
      n_vec++;
      if (f >= ss_q.size() || ss_q[f] != exp_ss[f]) begin
        n_err++;
        $display("FAIL %s start_cycle[%0d]: got %0d want %0d", nm, f,
                 (f < ss_q.size()) ? ss_q[f] : -1, exp_ss[f]);
      end
    end
    n_vec++;
    if (done_q.size() != 1 || done_q[0] != de) begin
      n_err++;
      $display("FAIL %s done_pulse: count=%0d first=%0d want count=1 at %0d",
               nm, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, de);
    end
    n_vec++;
    if (cap.sample_len !== len || err_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL %s shadow_len: sample_len=%0d err=%0b want %0d 0",
               nm, cap.sample_len, err_timeout, len);
    end
    resp_en = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({cap.sample_start, busy, done, err_timeout} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000",
               {cap.sample_start, busy, done, err_timeout});
    end
    n_vec++;
    if (frame_cnt !== 16'd0 || cap.sample_len !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counts: frame_cnt=%0d sample_len=%0d want 0 0",
               frame_cnt, cap.sample_len);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arm_ignored;
    done_q.delete();
    @(negedge clk);
    cfg_sample_len = 32'd0; cfg_frames = 16'd1; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL arm_len0: busy=%0b want 0", busy);
    end
    cfg_sample_len = 32'd5; arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done_q.size() != 0) begin
      n_err++;
      $display("FAIL arm_with_abort: busy=%0b dones=%0d want 0 0", busy, done_q.size());
    end
  endtask

  task automatic test_random;
    logic [31:0] len;
    for (int i = 0; i < 6; i++) begin
      len = $urandom;
      if (len == 32'd0) len = 32'd1;
      run_frames("random", len, $urandom_range(1, 3), $urandom_range(0, 5),
                 $urandom_range(0, 8), $urandom_range(1, 12), $urandom_range(0, 6));
    end
  endtask

  task automatic test_trigger;
    int ae, t, k;
    r_ack = 1; r_hi = 4; r_tl = 2; resp_en = 1'b1;
    ss_q.delete(); done_q.delete();
    ext_trig = 1'b1;
    do_arm(32'd16, 16'd1, 32'd0, 1'b1, ae);
    repeat (20) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || cap.sample_start !== 1'b0 || ss_q.size() != 0) begin
      n_err++;
      $display("FAIL trig_level_high: busy=%0b start=%0b starts=%0d want 1 0 0",
               busy, cap.sample_start, ss_q.size());
    end
    ext_trig = 1'b0;
    repeat (3) @(negedge clk);
    ext_trig = 1'b1;
    t = cyc + 1;
    k = 0;
    while (done_q.size() == 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    #1;
    n_vec++;
    if (ss_q.size() != 1 || ss_q[0] != t) begin
      n_err++;
      $display("FAIL trig_edge_start: count=%0d at=%0d want 1 at %0d",
               ss_q.size(), (ss_q.size() > 0) ? ss_q[0] : -1, t);
    end
    n_vec++;
    if (done_q.size() != 1 || done_q[0] != t + per_frame(1, 4, 2) ||
        frame_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL trig_done: count=%0d at=%0d frame_cnt=%0d want 1 at %0d cnt 1",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, frame_cnt,
               t + per_frame(1, 4, 2));
    end
    ext_trig = 1'b0; resp_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    int ae, hi_cnt;
    resp_en = 1'b0;
    done_q.delete();
    do_arm(32'd8, 16'd1, 32'd0, 1'b0, ae);
    hi_cnt = 0;
    while (cyc < ae + 18) begin
      @(negedge clk);
      if (cap.sample_start) hi_cnt++;
      if (cyc == ae + 17) begin
        n_vec++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
          n_err++;
          $display("FAIL timeout_error_state: err=%0b busy=%0b done=%0b want 1 0 0",
                   err_timeout, busy, done);
        end
      end
    end
    n_vec++;
    if (hi_cnt != ACK_TO) begin
      n_err++;
      $display("FAIL timeout_ack_cycles: got %0d want %0d", hi_cnt, ACK_TO);
    end
    n_vec++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || done_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout_sticky: err=%0b busy=%0b dones=%0d want 1 0 0",
               err_timeout, busy, done_q.size());
    end
  endtask

  task automatic test_abort;
    int ae, a, h, t, iv, per, e3, e1, k, x;
    a = $urandom_range(0, 4); h = $urandom_range(3, 8);
    t = $urandom_range(0, 4); iv = $urandom_range(0, 4);
    r_ack = a; r_hi = h; r_tl = t; resp_en = 1'b1;
    ss_q.delete(); done_q.delete();
    do_arm(32'd7, 16'd0, 32'(iv), 1'b0, ae);
    per = per_frame(a, h, t);
    e3 = ae + 1 + 2 * (per + ((iv > 0) ? iv : 1) + 1) + per;
    k = 0;
    while ((ss_q.size() < 3 || cap.st_clr !== 1'b1) && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= 300) begin
      n_err++;
      $display("FAIL abort_reach_frame3: starts=%0d want 3 within 300 cycles", ss_q.size());
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    while (cyc < e3 + 1) @(negedge clk);
    #1;
    n_vec++;
    if (done_q.size() != 1 || done_q[0] != e3 || frame_cnt !== 16'd3 ||
        ss_q.size() != 3 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_capture: dones=%0d at=%0d cnt=%0d starts=%0d want 1 at %0d cnt 3 starts 3",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, frame_cnt,
               ss_q.size(), e3);
    end
    repeat (2) @(negedge clk);

    ss_q.delete(); done_q.delete();
    do_arm(32'd7, 16'd0, 32'd6, 1'b0, ae);
    e1 = ae + 1 + per;
    while (cyc < e1 + 2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    while (cyc < e1 + 4) @(negedge clk);
    #1;
    n_vec++;
    if (done_q.size() != 1 || done_q[0] != e1 + 3 || frame_cnt !== 16'd1 ||
        ss_q.size() != 1) begin
      n_err++;
      $display("FAIL abort_interval: dones=%0d at=%0d cnt=%0d starts=%0d want 1 at %0d cnt 1 starts 1",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, frame_cnt,
               ss_q.size(), e1 + 3);
    end
    resp_en = 1'b0;

    ss_q.delete(); done_q.delete();
    ext_trig = 1'b0;
    do_arm(32'd7, 16'd0, 32'd0, 1'b1, ae);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    x = cyc + 1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (done_q.size() != 1 || done_q[0] != x || ss_q.size() != 0 ||
        frame_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL abort_wait_trig: dones=%0d at=%0d starts=%0d cnt=%0d want 1 at %0d 0 0",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, ss_q.size(),
               frame_cnt, x);
    end
  endtask

  task automatic test_rst_mid;
    int ae, k;
    resp_en = 1'b0;
    ss_q.delete(); done_q.delete();
    do_arm(32'd9, 16'd1, 32'd0, 1'b0, ae);
    @(negedge clk);
    n_vec++;
    if (cap.sample_start !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_ack: sample_start=%0b want 1", cap.sample_start);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (cap.sample_start !== 1'b0 || busy !== 1'b0 || cap.sample_len !== 32'd0) begin
      n_err++;
      $display("FAIL rst_in_ack: start=%0b busy=%0b len=%0d want 0 0 0",
               cap.sample_start, busy, cap.sample_len);
    end
    @(negedge clk);
    rst = 1'b0;

    r_ack = 0; r_hi = 30; r_tl = 2; resp_en = 1'b1;
    do_arm(32'd12, 16'd1, 32'd0, 1'b0, ae);
    k = 0;
    while (cap.st_clr !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || cap.sample_len !== 32'd12) begin
      n_err++;
      $display("FAIL rst_pre_capture: busy=%0b len=%0d want 1 12", busy, cap.sample_len);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({cap.sample_start, busy, done, err_timeout} !== 4'b0 ||
        frame_cnt !== 16'd0 || cap.sample_len !== 32'd0) begin
      n_err++;
      $display("FAIL rst_in_capture: flags=%b cnt=%0d len=%0d want 0000 0 0",
               {cap.sample_start, busy, done, err_timeout}, frame_cnt, cap.sample_len);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (resp_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    resp_en = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (done_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_no_done: dones=%0d busy=%0b want 0 0", done_q.size(), busy);
    end
    run_frames("post_rst", 32'd20, 2, 1, 1, 3, 1);
  endtask

  initial begin
    test_reset;
    test_arm_ignored;
    run_frames("basic", 32'd4, 2, 3, 2, 10, 5);
    run_frames("tlast_same", 32'd6, 2, 0, 1, 4, 0);
    test_random;
    test_trigger;
    test_timeout;
    run_frames("after_timeout", 32'd3, 1, 2, 0, 2, 1);
    test_abort;
    test_rst_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
